// File: rtl/song_sequencer_if.sv
// Control, ROM and tone-generator signals of the song sequencer.
// The slave side is the sequencer; the master side is the mode controller plus the song ROM.
interface song_sequencer_if #(
  parameter int unsigned ADDR_BITS = 6
);
  logic                 start;
  logic                 stop;
  logic                 pause;
  logic [1:0]           song_sel;
  logic [ADDR_BITS+1:0] rom_addr;
  logic [11:0]          rom_data;
  logic                 tone_en;
  logic [2:0]           tone_note;
  logic [1:0]           tone_oct;
  logic [6:0]           led;
  logic                 busy;
  logic                 done;
  logic [ADDR_BITS-1:0] note_idx;

  modport master (
    output start, stop, pause, song_sel, rom_data,
    input  rom_addr, tone_en, tone_note, tone_oct, led, busy, done, note_idx
  );

  modport slave (
    input  start, stop, pause, song_sel, rom_data,
    output rom_addr, tone_en, tone_note, tone_oct, led, busy, done, note_idx
  );
endinterface

// File: rtl/song_sequencer.sv
// Song player: fetches ROM entries, times each note and the trailing gap from a ms tick,
// and drives the tone generator and note LEDs.
module song_sequencer #(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned UNIT_MS   = 125,
  parameter int unsigned GAP_MS    = 20,
  parameter int unsigned ADDR_BITS = 6
) (
  input logic             clk,
  input logic             rst_n,
  song_sequencer_if.slave bus
);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MW = 16;
  localparam logic [PW-1:0]        PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [ADDR_BITS-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_PLAY, S_GAP, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           song_q,  song_d;
  logic [ADDR_BITS-1:0] idx_q,   idx_d;
  logic [PW-1:0]        pre_q,   pre_d;
  logic [MW-1:0]        ms_q,    ms_d;
  logic [2:0]           note_q,  note_d;
  logic [1:0]           oct_q,   oct_d;
  logic                 done_q,  done_d;
  logic                 tick;
  logic                 unused_rom_bits;

  assign unused_rom_bits = ^bus.rom_data[2:0];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      song_q  <= '0;
      idx_q   <= '0;
      pre_q   <= '0;
      ms_q    <= '0;
      note_q  <= '0;
      oct_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
      note_q  <= note_d;
      oct_q   <= oct_d;
      done_q  <= done_d;
    end
  end

  // Next-state, prescaler and ms-counter logic; pause freezes everything outside IDLE
  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    ms_d    = ms_q;
    note_d  = note_q;
    oct_d   = oct_q;
    tick    = 1'b0;

    if ((state_q == S_PLAY || state_q == S_GAP) && !bus.pause) begin
      tick  = (pre_q == PRE_LAST);
      pre_d = tick ? '0 : pre_q + PW'(1);
    end

    if (bus.stop) begin
      state_d = S_IDLE;
    end else if (state_q == S_IDLE) begin
      if (bus.start) begin
        song_d  = bus.song_sel;
        idx_d   = '0;
        state_d = S_FETCH;
      end
    end else if (!bus.pause) begin
      case (state_q)
        S_FETCH: state_d = S_LATCH;
        S_LATCH: begin
          note_d = bus.rom_data[11:9];
          oct_d  = (bus.rom_data[8:7] == 2'd3) ? 2'd1 : bus.rom_data[8:7];
          if (bus.rom_data[6:3] == 4'd0) begin
            state_d = S_DONE;
          end else begin
            ms_d    = MW'(bus.rom_data[6:3]) * MW'(UNIT_MS);
            pre_d   = '0;
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          if (tick) begin
            ms_d = ms_q - MW'(1);
            if (ms_q == MW'(1)) begin
              ms_d    = MW'(GAP_MS);
              pre_d   = '0;
              state_d = S_GAP;
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            ms_d = ms_q - MW'(1);
            if (ms_q == MW'(1)) begin
              // The index saturates: a full-length song ends instead of wrapping
              if (idx_q == IDX_LAST) begin
                state_d = S_DONE;
              end else begin
                idx_d   = idx_q + ADDR_BITS'(1);
                state_d = S_FETCH;
              end
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // Output decode from registered state and note registers
  assign bus.rom_addr  = {song_q, idx_q};
  assign bus.note_idx  = idx_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.tone_en   = (state_q == S_PLAY) && (note_q != 3'd0) && !bus.pause;
  assign bus.tone_note = (state_q != S_IDLE) ? note_q : 3'd0;
  assign bus.tone_oct  = (state_q != S_IDLE) ? oct_q : 2'd0;
  assign bus.led       = (state_q == S_PLAY && note_q != 3'd0) ?
                         7'(7'd1 << (note_q - 3'd1)) : 7'd0;
endmodule
